// File: rtl/core_out.sv
// ---------------------------------------------------------------------------
// core_out : byte output path of the core (FIFO + UART TX, 8N1 LSB first).
// Build option: define CORE_OUT_PARITY_EN for an even-parity bit (8E1).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module core_out #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       OUTE,
  input  logic [7:0] OUTDATA,
  output logic       OUT_BUSY,
  output logic       OVERFLOW,
  output logic       TX_IDLE,
  output logic       TXD
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int TW    = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] RELOAD   = TW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef CORE_OUT_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t state, state_nxt;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [CW-1:0]      count;
  logic               full, empty, push, pop;

  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bitcnt, bitcnt_nxt;
  logic [7:0]    sh, sh_nxt;
  logic          txd_nxt;
  logic          ovf;
  logic          txd_q;
`ifdef CORE_OUT_PARITY_EN
  logic          par, par_nxt;
`endif

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push     = OUTE && !full;
  assign OUT_BUSY = full;
  assign OVERFLOW = ovf;
  assign TX_IDLE  = empty && (state == S_IDLE);
  assign TXD      = txd_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Pop from IDLE or at the end of STOP so queued bytes go out with no gap.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    bitcnt_nxt = bitcnt;
    sh_nxt     = sh;
    pop        = 1'b0;
`ifdef CORE_OUT_PARITY_EN
    par_nxt    = par;
`endif
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          sh_nxt     = mem[rptr];
          bitcnt_nxt = 3'd0;
          timer_nxt  = RELOAD;
          state_nxt  = S_START;
`ifdef CORE_OUT_PARITY_EN
          par_nxt    = ^mem[rptr];
`endif
        end
      end
      S_START: begin
        if (timer == '0) begin
          timer_nxt = RELOAD;
          state_nxt = S_DATA;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_DATA: begin
        if (timer == '0) begin
          timer_nxt  = RELOAD;
          sh_nxt     = {1'b0, sh[7:1]};
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
`ifdef CORE_OUT_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
`ifdef CORE_OUT_PARITY_EN
      S_PARITY: begin
        if (timer == '0) begin
          timer_nxt = RELOAD;
          state_nxt = S_STOP;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (timer == '0) begin
          if (!empty) begin
            pop        = 1'b1;
            sh_nxt     = mem[rptr];
            bitcnt_nxt = 3'd0;
            timer_nxt  = RELOAD;
            state_nxt  = S_START;
`ifdef CORE_OUT_PARITY_EN
            par_nxt    = ^mem[rptr];
`endif
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // TXD is registered from the next state so the line never glitches.
  always_comb begin
    txd_nxt = 1'b1;
    case (state_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = sh_nxt[0];
`ifdef CORE_OUT_PARITY_EN
      S_PARITY: txd_nxt = par_nxt;
`endif
      default:  txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      timer  <= '0;
      bitcnt <= 3'd0;
      sh     <= 8'h00;
      txd_q  <= 1'b1;
`ifdef CORE_OUT_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      timer  <= timer_nxt;
      bitcnt <= bitcnt_nxt;
      sh     <= sh_nxt;
      txd_q  <= txd_nxt;
`ifdef CORE_OUT_PARITY_EN
      par    <= par_nxt;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= OUTDATA;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop)  rptr <= rptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (OUTE && full) ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_out.sv
// ---------------------------------------------------------------------------
// tb_core_out : directed self-checking bench for core_out (CLK_PER_BIT=4, FIFO_AW=2).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_core_out;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef CORE_OUT_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       CLK     = 1'b0;
  logic       RST_N   = 1'b0;
  logic       OUTE    = 1'b0;
  logic [7:0] OUTDATA = 8'h00;
  logic       OUT_BUSY, OVERFLOW, TX_IDLE, TXD;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  core_out #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .OUTE     (OUTE),
    .OUTDATA  (OUTDATA),
    .OUT_BUSY (OUT_BUSY),
    .OVERFLOW (OVERFLOW),
    .TX_IDLE  (TX_IDLE),
    .TXD      (TXD)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected line level for frame bit k: start, 8 data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Cycle i of a frame is the cycle after edge (pop edge + i).
  task automatic check_bits(input logic [7:0] b, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      tick();
      chk($sformatf("txd_%h_c%0d", b, i), {7'b0, TXD}, {7'b0, exp_bit(b, i / CPB)});
    end
  endtask

  initial begin
    logic bad;
    // ---------------- reset ----------------
    tick(); tick(); tick();
    RST_N = 1'b1;
    chk("rst_txd", {7'b0, TXD}, 8'd1);
    chk("rst_busy", {7'b0, OUT_BUSY}, 8'd0);
    chk("rst_ovf", {7'b0, OVERFLOW}, 8'd0);
    chk("rst_idle", {7'b0, TX_IDLE}, 8'd1);

    // ---------------- single byte A5 ----------------
    OUTE = 1'b1; OUTDATA = 8'hA5;
    tick();
    OUTE = 1'b0; OUTDATA = 8'h00;
    chk("a5_txd_pre", {7'b0, TXD}, 8'd1);
    chk("a5_idle_pre", {7'b0, TX_IDLE}, 8'd0);
    check_bits(8'hA5, 0, FRAME);
    chk("a5_idle_last", {7'b0, TX_IDLE}, 8'd0);
    tick();
    chk("a5_idle_end", {7'b0, TX_IDLE}, 8'd1);
    chk("a5_txd_end", {7'b0, TXD}, 8'd1);

    // ---------------- three back-to-back frames ----------------
    OUTE = 1'b1; OUTDATA = 8'h00; tick();
    OUTDATA = 8'hFF; tick();
    OUTDATA = 8'h55; tick();
    OUTE = 1'b0;
    check_bits(8'h00, 2, FRAME);
    check_bits(8'hFF, 0, FRAME);
    check_bits(8'h55, 0, FRAME);
    tick();
    chk("b2b_idle", {7'b0, TX_IDLE}, 8'd1);
    chk("b2b_ovf", {7'b0, OVERFLOW}, 8'd0);

    // ---------------- overflow: 6 pushes into depth 4 ----------------
    OUTE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      OUTDATA = 8'h10 + 8'(i);
      if (i == 5) chk("ovf_busy_at6", {7'b0, OUT_BUSY}, 8'd1);
      tick();
    end
    OUTE = 1'b0;
    chk("ovf_set", {7'b0, OVERFLOW}, 8'd1);
    check_bits(8'h10, 5, FRAME);
    check_bits(8'h11, 0, FRAME);
    check_bits(8'h12, 0, FRAME);
    check_bits(8'h13, 0, FRAME);
    check_bits(8'h14, 0, FRAME);
    tick();
    chk("ovf_idle_after5", {7'b0, TX_IDLE}, 8'd1);
    chk("ovf_sticky", {7'b0, OVERFLOW}, 8'd1);

    // ---------------- reset during DATA bit 3 of 3C ----------------
    OUTE = 1'b1; OUTDATA = 8'h3C; tick();
    OUTDATA = 8'h11; tick();
    OUTDATA = 8'h22; tick();
    OUTE = 1'b0;
    check_bits(8'h3C, 2, 18);
    chk("rstmid_busy_q", {7'b0, TX_IDLE}, 8'd0);
    RST_N = 1'b0;
    tick();
    chk("rstmid_txd", {7'b0, TXD}, 8'd1);
    chk("rstmid_idle", {7'b0, TX_IDLE}, 8'd1);
    chk("rstmid_ovf", {7'b0, OVERFLOW}, 8'd0);
    chk("rstmid_outbusy", {7'b0, OUT_BUSY}, 8'd0);
    RST_N = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (TXD !== 1'b1 || TX_IDLE !== 1'b1) bad = 1'b1;
    end
    chk("rstmid_quiet", {7'b0, bad}, 8'd0);

    // ---------------- full FIFO, push on the pop edge ----------------
    OUTE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      OUTDATA = 8'hE0 + 8'(i);
      tick();
    end
    OUTE = 1'b0;
    check_bits(8'hE0, 4, FRAME);
    OUTE = 1'b1; OUTDATA = 8'hEE;
    chk("popedge_busy_pre", {7'b0, OUT_BUSY}, 8'd1);
    chk("popedge_ovf_pre", {7'b0, OVERFLOW}, 8'd0);
    tick();
    OUTE = 1'b0;
    chk("popedge_ovf", {7'b0, OVERFLOW}, 8'd1);
    chk("popedge_busy", {7'b0, OUT_BUSY}, 8'd0);
    chk("popedge_start", {7'b0, TXD}, 8'd0);
    check_bits(8'hE1, 1, FRAME);
    check_bits(8'hE2, 0, FRAME);
    check_bits(8'hE3, 0, FRAME);
    check_bits(8'hE4, 0, FRAME);
    tick();
    chk("popedge_idle", {7'b0, TX_IDLE}, 8'd1);

    // ---------------- 07: parity/frame length ----------------
    OUTE = 1'b1; OUTDATA = 8'h07; tick();
    OUTE = 1'b0;
    check_bits(8'h07, 0, FRAME);
    chk("p07_idle_last", {7'b0, TX_IDLE}, 8'd0);
    tick();
    chk("p07_idle_end", {7'b0, TX_IDLE}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
